// File: rtl/axil_slave_regfile.sv
// AXI4-Lite responder that terminates a write/read link in a bank of 32-bit registers.
// Register 0 is a read-only ID word; writes to it are acknowledged but have no effect.
module axil_slave_regfile #(
    parameter int          C_AXI_DATA_WIDTH = 32,
    parameter int          C_AXI_ADDR_WIDTH = 8,
    parameter int          NUM_REGS         = 16,
    parameter logic [31:0] ID_VALUE         = 32'h5345_5255
) (
    input  logic                          AXI_ACLK,
    input  logic                          AXI_ARESET,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   AXI_AWADDR,
    input  logic [2:0]                    AXI_AWPROT,
    input  logic                          AXI_AWVALID,
    output logic                          AXI_AWREADY,
    input  logic [31:0]                   AXI_WDATA,
    input  logic [3:0]                    AXI_WSTRB,
    input  logic                          AXI_WVALID,
    output logic                          AXI_WREADY,
    output logic [1:0]                    AXI_BRESP,
    output logic                          AXI_BVALID,
    input  logic                          AXI_BREADY,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   AXI_ARADDR,
    input  logic [2:0]                    AXI_ARPROT,
    input  logic                          AXI_ARVALID,
    output logic                          AXI_ARREADY,
    output logic [31:0]                   AXI_RDATA,
    output logic [1:0]                    AXI_RRESP,
    output logic                          AXI_RVALID,
    input  logic                          AXI_RREADY,
    output logic [32*NUM_REGS-1:0]        regs_o,
    output logic [NUM_REGS-1:0]           wr_pulse_o
);

    localparam int                 IDX_W      = C_AXI_ADDR_WIDTH - 2;
    localparam logic [IDX_W:0]     NUM_REGS_L = (IDX_W + 1)'(NUM_REGS);
    localparam logic [1:0]         RESP_OKAY  = 2'b00;
    localparam logic [1:0]         RESP_SLV   = 2'b10;

    generate
        if (C_AXI_DATA_WIDTH != 32) begin : g_bad_data_width
            $error("axil_slave_regfile supports only a 32-bit data width");
        end
        if ((NUM_REGS < 2) || (NUM_REGS > (1 << IDX_W))) begin : g_bad_num_regs
            $error("axil_slave_regfile NUM_REGS outside the decodable range");
        end
    endgenerate

    logic             aw_held_q, aw_held_d;
    logic [IDX_W-1:0] aw_idx_q, aw_idx_d;
    logic             w_held_q, w_held_d;
    logic [31:0]      w_data_q, w_data_d;
    logic [3:0]       w_strb_q, w_strb_d;
    logic             bvalid_q, bvalid_d;
    logic [1:0]       bresp_q, bresp_d;
    logic             rvalid_q, rvalid_d;
    logic [1:0]       rresp_q, rresp_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
    logic [31:0]      regs_q [1:NUM_REGS-1];
    logic [31:0]      regs_d [1:NUM_REGS-1];

    logic             aw_hs_s, w_hs_s, ar_hs_s, commit_s, wr_en_s;
    logic             wr_in_range_s, rd_in_range_s;
    logic [IDX_W-1:0] cur_idx_s, ar_idx_s;
    logic [31:0]      cur_data_s, rd_word_s;
    logic [3:0]       cur_strb_s;
    logic             unused_s;

    assign unused_s = ^{AXI_AWPROT, AXI_ARPROT, AXI_AWADDR[1:0], AXI_ARADDR[1:0]};

    // Handshake readiness, gated off while reset is asserted.
    always_comb begin
        AXI_AWREADY = !aw_held_q && !bvalid_q && !AXI_ARESET;
        AXI_WREADY  = !w_held_q  && !bvalid_q && !AXI_ARESET;
        AXI_ARREADY = !rvalid_q  && !AXI_ARESET;
        AXI_BVALID  = bvalid_q;
        AXI_BRESP   = bresp_q;
        AXI_RVALID  = rvalid_q;
        AXI_RRESP   = rresp_q;
        AXI_RDATA   = rdata_q;
        wr_pulse_o  = wr_pulse_q;
    end

    // Flat register export with the ID word in slot 0.
    always_comb begin
        regs_o[31:0] = ID_VALUE;
        for (int i = 1; i < NUM_REGS; i++) begin
            regs_o[32*i +: 32] = regs_q[i];
        end
    end

    // Write path: capture AW/W independently, commit once both are available.
    always_comb begin
        aw_hs_s    = AXI_AWVALID && AXI_AWREADY;
        w_hs_s     = AXI_WVALID && AXI_WREADY;
        commit_s   = (aw_held_q || aw_hs_s) && (w_held_q || w_hs_s);
        cur_idx_s  = aw_held_q ? aw_idx_q : AXI_AWADDR[C_AXI_ADDR_WIDTH-1:2];
        cur_data_s = w_held_q ? w_data_q : AXI_WDATA;
        cur_strb_s = w_held_q ? w_strb_q : AXI_WSTRB;
        wr_in_range_s = ({1'b0, cur_idx_s} < NUM_REGS_L);
        wr_en_s    = commit_s && wr_in_range_s;

        aw_held_d = commit_s ? 1'b0 : (aw_hs_s ? 1'b1 : aw_held_q);
        aw_idx_d  = aw_hs_s ? AXI_AWADDR[C_AXI_ADDR_WIDTH-1:2] : aw_idx_q;
        w_held_d  = commit_s ? 1'b0 : (w_hs_s ? 1'b1 : w_held_q);
        w_data_d  = w_hs_s ? AXI_WDATA : w_data_q;
        w_strb_d  = w_hs_s ? AXI_WSTRB : w_strb_q;

        // No commit can coincide with a pending B, since AW/W are refused then.
        if (commit_s) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_in_range_s ? RESP_OKAY : RESP_SLV;
        end else if (bvalid_q && AXI_BREADY) begin
            bvalid_d = 1'b0;
            bresp_d  = bresp_q;
        end else begin
            bvalid_d = bvalid_q;
            bresp_d  = bresp_q;
        end

        wr_pulse_d = {NUM_REGS{1'b0}};
        for (int i = 1; i < NUM_REGS; i++) begin
            if (wr_en_s && (cur_idx_s == IDX_W'(i))) begin
                wr_pulse_d[i] = 1'b1;
                for (int b = 0; b < 4; b++) begin
                    regs_d[i][8*b +: 8] = cur_strb_s[b] ? cur_data_s[8*b +: 8]
                                                        : regs_q[i][8*b +: 8];
                end
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    // Read path: sample the addressed register at the AR handshake, hold until R completes.
    always_comb begin
        ar_hs_s       = AXI_ARVALID && AXI_ARREADY;
        ar_idx_s      = AXI_ARADDR[C_AXI_ADDR_WIDTH-1:2];
        rd_in_range_s = ({1'b0, ar_idx_s} < NUM_REGS_L);
        rd_word_s     = (ar_idx_s == {IDX_W{1'b0}}) ? ID_VALUE : 32'h0000_0000;
        for (int i = 1; i < NUM_REGS; i++) begin
            rd_word_s = (ar_idx_s == IDX_W'(i)) ? regs_q[i] : rd_word_s;
        end

        if (ar_hs_s) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_in_range_s ? rd_word_s : 32'h0000_0000;
            rresp_d  = rd_in_range_s ? RESP_OKAY : RESP_SLV;
        end else if (rvalid_q && AXI_RREADY) begin
            rvalid_d = 1'b0;
            rdata_d  = 32'h0000_0000;
            rresp_d  = RESP_OKAY;
        end else begin
            rvalid_d = rvalid_q;
            rdata_d  = rdata_q;
            rresp_d  = rresp_q;
        end
    end

    // State registers with synchronous reset; reset discards any in-flight transfer.
    always_ff @(posedge AXI_ACLK) begin
        if (AXI_ARESET) begin
            aw_held_q  <= 1'b0;
            aw_idx_q   <= {IDX_W{1'b0}};
            w_held_q   <= 1'b0;
            w_data_q   <= 32'h0000_0000;
            w_strb_q   <= 4'h0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            rvalid_q   <= 1'b0;
            rresp_q    <= 2'b00;
            rdata_q    <= 32'h0000_0000;
            wr_pulse_q <= {NUM_REGS{1'b0}};
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= 32'h0000_0000;
            end
        end else begin
            aw_held_q  <= aw_held_d;
            aw_idx_q   <= aw_idx_d;
            w_held_q   <= w_held_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            wr_pulse_q <= wr_pulse_d;
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

endmodule

// File: tb/tb_axil_slave_regfile.sv
// Directed bench for axil_slave_regfile with a reference register model and B/R scoreboards.
module tb_axil_slave_regfile;

    localparam logic [31:0] ID = 32'h5345_5255;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic [7:0]  awaddr = 8'h00, araddr = 8'h00;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] wdata = 32'h0;
    logic [3:0]  wstrb = 4'h0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [511:0] regs;
    logic [15:0] pulse;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] mdl [0:15];
    logic [1:0]  b_q [$];
    logic [33:0] r_q [$];

    axil_slave_regfile dut (
        .AXI_ACLK(clk), .AXI_ARESET(arst),
        .AXI_AWADDR(awaddr), .AXI_AWPROT(3'b000), .AXI_AWVALID(awvalid), .AXI_AWREADY(awready),
        .AXI_WDATA(wdata), .AXI_WSTRB(wstrb), .AXI_WVALID(wvalid), .AXI_WREADY(wready),
        .AXI_BRESP(bresp), .AXI_BVALID(bvalid), .AXI_BREADY(bready),
        .AXI_ARADDR(araddr), .AXI_ARPROT(3'b000), .AXI_ARVALID(arvalid), .AXI_ARREADY(arready),
        .AXI_RDATA(rdata), .AXI_RRESP(rresp), .AXI_RVALID(rvalid), .AXI_RREADY(rready),
        .regs_o(regs), .wr_pulse_o(pulse)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] exp_regs();
        logic [511:0] r;
        r[31:0] = ID;
        for (int i = 1; i < 16; i++) r[32*i +: 32] = mdl[i];
        return r;
    endfunction

    function automatic logic [15:0] model_write(input logic [7:0] addr, input logic [31:0] d,
                                                input logic [3:0] s);
        int idx;
        logic [15:0] p;
        idx = int'(addr[7:2]);
        p = 16'h0000;
        if (idx > 0 && idx < 16) begin
            p[idx] = 1'b1;
            for (int b = 0; b < 4; b++) if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
        end
        b_q.push_back((idx < 16) ? 2'b00 : 2'b10);
        return p;
    endfunction

    task automatic check_b(input string tag);
        chk({tag, "_bvalid"}, bvalid, 1'b1);
        if (b_q.size() > 0) chk({tag, "_bresp"}, bresp, b_q.pop_front());
        else chk({tag, "_bq_empty"}, b_q.size(), 1);
    endtask

    task automatic check_r(input string tag);
        chk({tag, "_rvalid"}, rvalid, 1'b1);
        if (r_q.size() > 0) chk({tag, "_rdata_rresp"}, {rresp, rdata}, r_q.pop_front());
        else chk({tag, "_rq_empty"}, r_q.size(), 1);
    endtask

    task automatic do_write(input string tag, input logic [7:0] addr, input logic [31:0] d,
                            input logic [3:0] s);
        int n;
        logic [15:0] ep;
        ep = model_write(addr, d, s);
        awaddr = addr; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        while (!(awready && wready) && n < 20) begin tick; n++; end
        chk({tag, "_aw_w_ready_timeout"}, (n < 20), 1'b1);
        tick;
        awvalid = 1'b0; wvalid = 1'b0;
        check_b(tag);
        chk({tag, "_regs"}, regs, exp_regs());
        chk({tag, "_pulse"}, pulse, ep);
        tick;
        chk({tag, "_pulse_clear"}, pulse, 16'h0000);
        chk({tag, "_bvalid_clear"}, bvalid, 1'b0);
    endtask

    task automatic do_read(input string tag, input logic [7:0] addr);
        int n;
        int idx;
        idx = int'(addr[7:2]);
        r_q.push_back((idx == 0) ? {2'b00, ID} : (idx < 16) ? {2'b00, mdl[idx]} : {2'b10, 32'h0});
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (!arready && n < 20) begin tick; n++; end
        chk({tag, "_arready_timeout"}, (n < 20), 1'b1);
        tick;
        arvalid = 1'b0;
        check_r(tag);
        tick;
        chk({tag, "_rvalid_clear"}, rvalid, 1'b0);
        rready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mdl[i] = 32'h0;

        // Reset state
        tick; tick;
        chk("rst_awready", awready, 1'b0);
        chk("rst_arready", arready, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_regs", regs, exp_regs());
        chk("rst_pulse", pulse, 16'h0000);
        arst = 1'b0;
        #1;
        chk("post_rst_readies", {awready, wready, arready}, 3'b111);

        // Same-cycle AW+W, then readback
        do_write("wr_r1", 8'h04, 32'hDEAD_BEEF, 4'hF);
        do_read("rd_r1", 8'h04);

        // W first, AW three cycles later, partial strobe
        wdata = 32'h1122_3344; wstrb = 4'h5; wvalid = 1'b1; bready = 1'b1;
        tick;
        wvalid = 1'b0;
        chk("wfirst_wready_low", wready, 1'b0);
        tick; tick;
        chk("wfirst_reg2_unchanged", regs[95:64], 32'h0000_0000);
        chk("wfirst_no_b", bvalid, 1'b0);
        void'(model_write(8'h08, 32'h1122_3344, 4'h5));
        awaddr = 8'h08; awvalid = 1'b1;
        tick;
        awvalid = 1'b0;
        check_b("wfirst");
        chk("wfirst_reg2", regs[95:64], 32'h0022_0044);
        chk("wfirst_pulse", pulse, 16'h0004);
        tick;

        // Back-pressured B: response stable, new AW/W refused until B handshake
        bready = 1'b0;
        void'(model_write(8'h10, 32'h1234_5678, 4'hF));
        awaddr = 8'h10; awvalid = 1'b1; wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1'b1;
        tick;
        awaddr = 8'h14; wdata = 32'h0000_00AA; wstrb = 4'h1;
        check_b("bp_first");
        for (int k = 0; k < 5; k++) begin
            chk("bp_bvalid_hold", {bvalid, bresp}, 3'b100);
            chk("bp_readies_low", {awready, wready}, 2'b00);
            tick;
        end
        bready = 1'b1;
        chk("bp_awready_before_b", awready, 1'b0);
        tick;
        chk("bp_awready_after_b", {bvalid, awready, wready}, 3'b011);
        chk("bp_reg5_untouched", regs[191:160], 32'h0000_0000);
        void'(model_write(8'h14, 32'h0000_00AA, 4'h1));
        tick;
        awvalid = 1'b0; wvalid = 1'b0;
        check_b("bp_second");
        chk("bp_regs", regs, exp_regs());
        chk("bp_pulse", pulse, 16'h0020);
        tick;

        // Out-of-range and ID register accesses
        do_write("wr_oor", 8'h40, 32'hFFFF_FFFF, 4'hF);
        do_read("rd_oor", 8'h40);
        do_read("rd_id", 8'h00);
        do_write("wr_id", 8'h00, 32'h0BAD_0BAD, 4'hF);
        do_read("rd_id_again", 8'h03);

        // Read and write to the same register on the same edge
        do_write("wr_r3", 8'h0C, 32'h0BAD_F00D, 4'hF);
        r_q.push_back({2'b00, 32'h0BAD_F00D});
        araddr = 8'h0C; arvalid = 1'b1; rready = 1'b0;
        void'(model_write(8'h0C, 32'hA5A5_A5A5, 4'hF));
        awaddr = 8'h0C; awvalid = 1'b1; wdata = 32'hA5A5_A5A5; wstrb = 4'hF; wvalid = 1'b1;
        bready = 1'b1;
        tick;
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        check_r("rw_same");
        check_b("rw_same");
        chk("rw_regs", regs, exp_regs());
        for (int k = 0; k < 4; k++) begin
            chk("rw_rdata_hold", {rvalid, rresp, rdata}, {3'b100, 32'h0BAD_F00D});
            chk("rw_arready_low", arready, 1'b0);
            tick;
        end
        rready = 1'b1;
        tick;
        rready = 1'b0;
        chk("rw_r_done", {rvalid, rdata, arready}, {1'b0, 32'h0, 1'b1});
        do_read("rd_r3_new", 8'h0C);

        // Reset with a pending B
        bready = 1'b0;
        void'(model_write(8'h18, 32'hCAFE_F00D, 4'hF));
        awaddr = 8'h18; awvalid = 1'b1; wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1'b1;
        tick;
        awvalid = 1'b0; wvalid = 1'b0;
        check_b("pre_rst");
        arst = 1'b1;
        tick;
        for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
        chk("mid_rst_bvalid", bvalid, 1'b0);
        chk("mid_rst_regs", regs, exp_regs());
        chk("mid_rst_readies", {awready, wready, arready}, 3'b000);
        arst = 1'b0;
        #1;
        chk("after_rst_readies", {awready, wready, arready}, 3'b111);

        // Reset with a held W: the captured data must be discarded
        wdata = 32'hFFFF_FFFF; wstrb = 4'hF; wvalid = 1'b1;
        tick;
        wvalid = 1'b0;
        chk("w_held", wready, 1'b0);
        arst = 1'b1;
        tick;
        arst = 1'b0;
        #1;
        chk("w_drop_wready", wready, 1'b1);
        awaddr = 8'h04; awvalid = 1'b1;
        tick;
        awvalid = 1'b0;
        chk("w_drop_no_commit", {bvalid, awready}, 2'b00);
        chk("w_drop_reg1", regs[63:32], 32'h0000_0000);
        void'(model_write(8'h04, 32'h0000_0077, 4'h1));
        wdata = 32'h0000_0077; wstrb = 4'h1; wvalid = 1'b1; bready = 1'b1;
        tick;
        wvalid = 1'b0;
        check_b("aw_then_w");
        chk("aw_then_w_regs", regs, exp_regs());
        chk("aw_then_w_pulse", pulse, 16'h0002);
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
